// File: rtl/gemm_result_drain.sv
// gemm_result_drain: captures a DIM x DIM GEMM result and streams it one element per handshake.
// Row-major traversal by default; define GEMM_DRAIN_COLMAJOR_EN for column-major traversal.
module gemm_result_drain #(
    parameter int DIM      = 16,
    parameter int OUT_BITS = 16,
    localparam int IW      = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [DIM-1:0][DIM-1:0][OUT_BITS-1:0] res_in,
    input  logic                                 res_valid,
    output logic                                 res_ready,
    output logic [OUT_BITS-1:0]                  m_data,
    output logic [IW-1:0]                        m_row,
    output logic [IW-1:0]                        m_col,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic                                 m_eol,
    output logic                                 m_last,
    output logic                                 overrun,
    input  logic                                 clr_overrun
);

    typedef enum logic {IDLE, STREAM} state_t;

    localparam logic [IW-1:0] LAST = IW'(DIM - 1);

    state_t                               state, state_nxt;
    logic [IW-1:0]                        inner, outer;
    logic [DIM-1:0][DIM-1:0][OUT_BITS-1:0] res_buf;
    logic                                 hs, cap, drop, at_eol, at_last;

    assign hs      = m_valid & m_ready;
    assign at_eol  = (inner == LAST);
    assign at_last = at_eol & (outer == LAST);

    assign m_valid   = (state == STREAM);
    assign m_eol     = m_valid & at_eol;
    assign m_last    = m_valid & at_last;
    // Ready opens on the final beat so back-to-back matrices stream with no bubble.
    assign res_ready = (state == IDLE) | (hs & m_last);
    assign cap       = res_valid & res_ready;
    assign drop      = res_valid & ~res_ready;

`ifdef GEMM_DRAIN_COLMAJOR_EN
    assign m_row = inner;
    assign m_col = outer;
`else
    assign m_row = outer;
    assign m_col = inner;
`endif

    assign m_data = res_buf[m_row][m_col];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cap) state_nxt = STREAM;
            STREAM:  if (hs && m_last) state_nxt = cap ? STREAM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inner <= '0;
            outer <= '0;
        end else if (cap) begin
            inner <= '0;
            outer <= '0;
        end else if (hs) begin
            if (at_eol) begin
                inner <= '0;
                outer <= at_last ? '0 : outer + 1'b1;
            end else begin
                inner <= inner + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  res_buf <= '0;
        else if (cap)  res_buf <= res_in;
    end

    // Set has priority so a drop in the same cycle as a clear is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         overrun <= 1'b0;
        else if (drop)        overrun <= 1'b1;
        else if (clr_overrun) overrun <= 1'b0;
    end

endmodule

// File: tb/tb_gemm_result_drain.sv
// Directed bench for gemm_result_drain (DIM=4): scoreboard of expected beats checked at each handshake.
module tb_gemm_result_drain;

    localparam int DIM = 4;
    localparam int OB  = 16;
    localparam int IW  = 2;

    typedef struct {
        logic [OB-1:0] data;
        logic [IW-1:0] row;
        logic [IW-1:0] col;
        logic          eol;
        logic          last;
    } beat_t;

    logic                            clk = 1'b0;
    logic                            reset_n = 1'b0;
    logic [DIM-1:0][DIM-1:0][OB-1:0] res_in = '0;
    logic                            res_valid = 1'b0;
    logic                            res_ready;
    logic [OB-1:0]                   m_data;
    logic [IW-1:0]                   m_row, m_col;
    logic                            m_valid;
    logic                            m_ready = 1'b1;
    logic                            m_eol, m_last, overrun;
    logic                            clr_overrun = 1'b0;

    int    checks = 0;
    int    fails  = 0;
    int    hs_total = 0;
    int    hs_base;
    int    rdy_mode = 0;
    int    tog = 0;
    beat_t sb[$];
    beat_t held;
    bit    stalled = 1'b0;

    gemm_result_drain #(.DIM(DIM), .OUT_BITS(OB)) dut (
        .clk(clk), .reset_n(reset_n), .res_in(res_in), .res_valid(res_valid),
        .res_ready(res_ready), .m_data(m_data), .m_row(m_row), .m_col(m_col),
        .m_valid(m_valid), .m_ready(m_ready), .m_eol(m_eol), .m_last(m_last),
        .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumer ready: 0 = always ready, 1 = repeating 1,0,0, else never ready.
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: m_ready = 1'b1;
            1: begin
                m_ready = (tog == 0);
                tog = (tog == 2) ? 0 : tog + 1;
            end
            default: m_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (reset_n && m_valid) begin
            if (stalled) begin
                chk("hold_data", 32'(m_data), 32'(held.data));
                chk("hold_idx",  32'({m_row, m_col}), 32'({held.row, held.col}));
                chk("hold_flags", 32'({m_eol, m_last}), 32'({held.eol, held.last}));
            end
            held.data = m_data; held.row = m_row; held.col = m_col;
            held.eol = m_eol;   held.last = m_last;
            if (m_ready) begin
                beat_t e;
                hs_total++;
                checks++;
                assert (sb.size() > 0) else begin
                    fails++;
                    $error("FAIL extra_beat: got beat %0h with empty scoreboard, expected none", m_data);
                end
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("beat_data", 32'(m_data), 32'(e.data));
                    chk("beat_idx",  32'({m_row, m_col}), 32'({e.row, e.col}));
                    chk("beat_eol",  32'(m_eol), 32'(e.eol));
                    chk("beat_last", 32'(m_last), 32'(e.last));
                end
            end
            stalled = !m_ready;
        end else begin
            stalled = 1'b0;
        end
    end

    task automatic drive(input bit alt, input bit push);
        beat_t e;
        int r, c;
        for (int rr = 0; rr < DIM; rr++)
            for (int cc = 0; cc < DIM; cc++)
                res_in[rr][cc] = alt ? 16'hA000 + 16'(4*rr + cc) : 16'(256*rr + cc);
        if (push)
            for (int o = 0; o < DIM; o++)
                for (int i = 0; i < DIM; i++) begin
`ifdef GEMM_DRAIN_COLMAJOR_EN
                    r = i; c = o;
`else
                    r = o; c = i;
`endif
                    e.data = res_in[r][c];
                    e.row  = IW'(r);
                    e.col  = IW'(c);
                    e.eol  = (i == DIM-1);
                    e.last = (i == DIM-1) && (o == DIM-1);
                    sb.push_back(e);
                end
    endtask

    // Called at posedge+1; returns at posedge+1 after the capturing edge.
    task automatic pulse_valid();
        res_valid = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
    endtask

    task automatic wait_hs(input int n);
        int k = 0;
        while ((hs_total - hs_base) < n && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        chk("wait_hs", 32'(hs_total - hs_base), 32'(n));
    endtask

    // Returns at the negedge after the final handshake edge.
    task automatic wait_drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_ready", 32'(res_ready), 32'd1);
        chk("rst_data",  32'(m_data), 32'd0);
        chk("rst_flags", 32'({m_eol, m_last, overrun}), 32'd0);
        chk("rst_idx",   32'({m_row, m_col}), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Single matrix, ready held high
        hs_base = hs_total;
        drive(0, 1);
        pulse_valid();
        chk("latency", 32'(m_valid), 32'd1);
        wait_drain(100);
        chk("idle_valid", 32'(m_valid), 32'd0);
        chk("idle_ready", 32'(res_ready), 32'd1);
        chk("hs_count1", 32'(hs_total - hs_base), 32'd16);

        // Stalling consumer
        rdy_mode = 1; tog = 0;
        @(posedge clk); #1;
        hs_base = hs_total;
        drive(0, 1);
        pulse_valid();
        wait_drain(200);
        chk("hs_count2", 32'(hs_total - hs_base), 32'd16);
        chk("idle_valid2", 32'(m_valid), 32'd0);
        rdy_mode = 0;
        @(posedge clk); @(posedge clk); #1;

        // Back-to-back matrices on the last handshake
        hs_base = hs_total;
        drive(0, 1);
        pulse_valid();
        begin
            int k = 0;
            while (!(m_valid && m_last) && k < 100) begin
                @(posedge clk); #1;
                k++;
            end
        end
        chk("wait_last", 32'(m_last), 32'd1);
        drive(1, 1);
        res_valid = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0;
        @(negedge clk);
        chk("b2b_valid", 32'(m_valid), 32'd1);
        chk("b2b_data",  32'(m_data), 32'hA000);
        chk("b2b_idx",   32'({m_row, m_col}), 32'd0);
        chk("b2b_ovr",   32'(overrun), 32'd0);
        wait_drain(100);
        chk("hs_count3", 32'(hs_total - hs_base), 32'd32);
        @(posedge clk); #1;

        // Overrun: drop mid-stream, set wins over clear, then clear
        hs_base = hs_total;
        drive(0, 1);
        pulse_valid();
        wait_hs(5);
        drive(1, 0);
        pulse_valid();
        @(negedge clk);
        chk("ovr_set", 32'(overrun), 32'd1);
        @(posedge clk); #1;
        wait_hs(10);
        res_valid = 1'b1; clr_overrun = 1'b1;
        @(posedge clk); #1;
        res_valid = 1'b0; clr_overrun = 1'b0;
        @(negedge clk);
        chk("ovr_setwins", 32'(overrun), 32'd1);
        wait_drain(100);
        chk("hs_count4", 32'(hs_total - hs_base), 32'd16);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        @(posedge clk); #1;
        clr_overrun = 1'b1;
        @(posedge clk); #1;
        clr_overrun = 1'b0;
        @(negedge clk);
        chk("ovr_clr", 32'(overrun), 32'd0);
        @(posedge clk); #1;

        // Reset mid-stream
        hs_base = hs_total;
        drive(0, 1);
        pulse_valid();
        wait_hs(3);
        pulse_valid();
        wait_hs(7);
        chk("pre_rst_ovr", 32'(overrun), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_ovr",   32'(overrun), 32'd0);
        chk("mid_rst_ready", 32'(res_ready), 32'd1);
        sb.delete();
        hs_base = hs_total;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid_rst_data", 32'(m_data), 32'd0);
        chk("mid_rst_nobeat", 32'(hs_total - hs_base), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        hs_base = hs_total;
        drive(0, 1);
        pulse_valid();
        @(negedge clk);
        chk("post_rst_idx", 32'({m_row, m_col}), 32'd0);
        wait_drain(100);
        chk("hs_count5", 32'(hs_total - hs_base), 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
